// File: rtl/ahb_gpio_multi.sv
`default_nettype none
//==============================================================================
// Module      : ahb_gpio_multi
// Description : AHB-Lite GPIO slave with a WIDTH-bit port.
//               - per-bit direction (GPIOOE = DIR)
//               - SYNC_STAGES-deep input synchroniser
//               - per-bit edge interrupts with enable, polarity and sticky
//                 write-1-to-clear status
//               - parity generation on GPIOOUT[WIDTH] and parity checking of
//                 GPIOIN[WIDTH:0] when the GPIO_PARITY_EN macro is defined
//
// Optional feature macro: GPIO_PARITY_EN
//   defined   : parity generated on DATA writes, input parity checked while
//               every bit is an input, sticky PAR_STAT[0] / PARITYERR.
//   undefined : GPIOOUT[WIDTH] = 0, GPIOIN[WIDTH], PARITYSEL and
//               INJECT_FAULT ignored, PAR_STAT reads 0, PARITYERR = 0.
//
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY   AHB-Lite slave inputs
//   HREADYOUT, HRDATA   AHB-Lite slave outputs (zero wait states)
//   GPIOIN  [WIDTH:0]   pad inputs  {parity, data}
//   GPIOOUT [WIDTH:0]   pad outputs {parity, data}
//   GPIOOE  [WIDTH-1:0] output enables
//   PARITYSEL           0 = even, 1 = odd parity
//   INJECT_FAULT        inverts generated parity and the check reference
//   IRQ                 registered OR of IRQ_STATUS
//   PARITYERR           sticky parity error flag
//
// Register map (byte offsets): 0x00 DATA, 0x04 DIR, 0x08 IRQ_EN,
//   0x0C IRQ_POL, 0x10 IRQ_STATUS (W1C), 0x14 PAR_STAT (bit0, W1C)
//
// Revision    : 1.0 - initial release
//==============================================================================
module ahb_gpio_multi #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH:0]   GPIOIN,
  output logic [WIDTH:0]   GPIOOUT,
  output logic [WIDTH-1:0] GPIOOE,
  input  logic             PARITYSEL,
  input  logic             INJECT_FAULT,
  output logic             IRQ,
  output logic             PARITYERR
);

  localparam logic [7:0] c_ofs_data = 8'h00;
  localparam logic [7:0] c_ofs_dir  = 8'h04;
  localparam logic [7:0] c_ofs_en   = 8'h08;
  localparam logic [7:0] c_ofs_pol  = 8'h0C;
  localparam logic [7:0] c_ofs_stat = 8'h10;
  localparam logic [7:0] c_ofs_par  = 8'h14;

`ifdef GPIO_PARITY_EN
  localparam int c_sync_w = WIDTH + 1;
`else
  localparam int c_sync_w = WIDTH;
`endif

  // ---------------------------------------------------------------------------
  // Address phase capture
  // ---------------------------------------------------------------------------
  logic       act_q;
  logic       wr_q;
  logic [7:0] addr_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else if (HREADY) begin
      act_q  <= HSEL & HTRANS[1];
      wr_q   <= HWRITE;
      addr_q <= HADDR[7:0];
    end
  end

  // A write commits on the edge that ends its data phase.
  logic w_wen;
  assign w_wen = act_q & wr_q & HREADY;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [c_sync_w-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= GPIOIN[c_sync_w-1:0];
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [c_sync_w-1:0] w_synced;
  logic [WIDTH-1:0]    w_syn_data;
  assign w_synced   = sync_q[SYNC_STAGES-1];
  assign w_syn_data = w_synced[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] dout_q, dir_q, dirp_q, en_q, pol_q, stat_q, prev_q;
  logic [WIDTH-1:0] stat_d;
  logic             par_q, perr_q, perr_d, irq_q;
  logic             w_par_gen;
  logic             w_unused;

  // Edge detection against the previous synced value. A bit that was an
  // output in the previous cycle is masked, so switching it to input cannot
  // produce an edge from stale history.
  logic [WIDTH-1:0] w_rise, w_fall, w_set, w_stat_clr;
  assign w_rise     = w_syn_data & ~prev_q;
  assign w_fall     = ~w_syn_data & prev_q;
  assign w_set      = ((pol_q & w_fall) | (~pol_q & w_rise)) & en_q & ~dir_q & ~dirp_q;
  assign w_stat_clr = (w_wen && (addr_q == c_ofs_stat)) ? HWDATA[WIDTH-1:0] : '0;
  // Set wins over a same-cycle clear.
  assign stat_d     = (stat_q & ~w_stat_clr) | w_set;

`ifdef GPIO_PARITY_EN
  logic w_par_ref, w_par_err, w_par_clr;
  assign w_par_ref = PARITYSEL ^ INJECT_FAULT;
  // Check only while the whole port is an input.
  assign w_par_err = (dir_q == '0) && ((^w_synced) != w_par_ref);
  assign w_par_clr = w_wen && (addr_q == c_ofs_par) && HWDATA[0];
  assign w_par_gen = (^HWDATA[WIDTH-1:0]) ^ w_par_ref;
  assign perr_d    = (perr_q & ~w_par_clr) | w_par_err;
  assign w_unused  = ^{HADDR[31:8], HTRANS[0], HWDATA[31:WIDTH]};
`else
  assign w_par_gen = 1'b0;
  assign perr_d    = 1'b0;
  assign w_unused  = ^{HADDR[31:8], HTRANS[0], HWDATA[31:WIDTH],
                       PARITYSEL, INJECT_FAULT, GPIOIN[WIDTH]};
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dout_q <= '0;
      dir_q  <= '0;
      dirp_q <= '0;
      en_q   <= '0;
      pol_q  <= '0;
      stat_q <= '0;
      prev_q <= '0;
      par_q  <= 1'b0;
      perr_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= w_syn_data;
      dirp_q <= dir_q;
      stat_q <= stat_d;
      perr_q <= perr_d;
      irq_q  <= |stat_q;
      if (w_wen) begin
        case (addr_q)
          c_ofs_data: begin
            dout_q <= HWDATA[WIDTH-1:0];
            par_q  <= w_par_gen;
          end
          c_ofs_dir: dir_q <= HWDATA[WIDTH-1:0];
          c_ofs_en:  en_q  <= HWDATA[WIDTH-1:0];
          c_ofs_pol: pol_q <= HWDATA[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data (combinational from the registered address)
  // ---------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (act_q && !wr_q) begin
      case (addr_q)
        c_ofs_data: w_rdata[WIDTH-1:0] = (dir_q & dout_q) | (~dir_q & w_syn_data);
        c_ofs_dir:  w_rdata[WIDTH-1:0] = dir_q;
        c_ofs_en:   w_rdata[WIDTH-1:0] = en_q;
        c_ofs_pol:  w_rdata[WIDTH-1:0] = pol_q;
        c_ofs_stat: w_rdata[WIDTH-1:0] = stat_q;
        c_ofs_par:  w_rdata[0]         = perr_q;
        default: ;
      endcase
    end
  end

  assign HRDATA    = w_rdata;
  assign HREADYOUT = 1'b1;
  assign GPIOOUT   = {par_q, dout_q};
  assign GPIOOE    = dir_q;
  assign IRQ       = irq_q;
  assign PARITYERR = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_gpio_multi.sv
`default_nettype none
//==============================================================================
// Module      : tb_ahb_gpio_multi
// Description : Directed self-checking bench for ahb_gpio_multi. A behavioural
//               model (pad history array + register state) predicts outputs;
//               a negedge process compares pad/IRQ outputs every cycle, and
//               reads are compared against the model and hand-computed values.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ahb_gpio_multi;

  localparam int WIDTH = 16;
  localparam int SYNC  = 2;
`ifdef GPIO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic             HSEL = 1'b0;
  logic [31:0]      HADDR = '0;
  logic [1:0]       HTRANS = 2'b00;
  logic             HWRITE = 1'b0;
  logic [31:0]      HWDATA = '0;
  logic             HREADY = 1'b1;
  logic             HREADYOUT;
  logic [31:0]      HRDATA;
  logic [WIDTH:0]   GPIOIN = '0;
  logic [WIDTH:0]   GPIOOUT;
  logic [WIDTH-1:0] GPIOOE;
  logic             PARITYSEL = 1'b0;
  logic             INJECT_FAULT = 1'b0;
  logic             IRQ;
  logic             PARITYERR;

  always #5 HCLK = ~HCLK;

  ahb_gpio_multi #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .GPIOIN(GPIOIN),
    .GPIOOUT(GPIOOUT), .GPIOOE(GPIOOE), .PARITYSEL(PARITYSEL),
    .INJECT_FAULT(INJECT_FAULT), .IRQ(IRQ), .PARITYERR(PARITYERR)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ph[k] = pad value sampled k edges ago; synced value = pad SYNC-1 edges ago.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] m_dout = '0, m_dir = '0, m_dirp = '0, m_en = '0, m_pol = '0, m_stat = '0;
  logic             m_par = 1'b0, m_perr = 1'b0, m_irq = 1'b0, m_pend = 1'b0;
  logic [7:0]       m_paddr = '0;
  logic [WIDTH:0]   ph [0:7];
  logic [WIDTH:0]   t_syn, t_prv;
  logic [WIDTH-1:0] t_set, t_clr;
  logic             t_pe, t_pclr;

  always @(posedge HCLK) begin : model
    if (HRESET) begin
      m_dout <= '0; m_dir <= '0; m_dirp <= '0; m_en <= '0; m_pol <= '0; m_stat <= '0;
      m_par <= 1'b0; m_perr <= 1'b0; m_irq <= 1'b0; m_pend <= 1'b0; m_paddr <= '0;
      for (int k = 0; k < 8; k++) ph[k] <= '0;
    end else begin
      t_syn = ph[SYNC-1];
      t_prv = ph[SYNC];
      t_set = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (m_en[i] && !m_dir[i] && !m_dirp[i] &&
            (m_pol[i] ? (t_prv[i] && !t_syn[i]) : (!t_prv[i] && t_syn[i])))
          t_set[i] = 1'b1;
      end
      t_pe   = PAR_EN && (m_dir == '0) &&
               (($countones(t_syn) % 2) != int'(PARITYSEL ^ INJECT_FAULT));
      t_clr  = '0;
      t_pclr = 1'b0;
      m_dirp <= m_dir;
      if (m_pend && HREADY) begin
        case (m_paddr)
          8'h00: begin
            m_dout <= HWDATA[WIDTH-1:0];
            m_par  <= PAR_EN &&
                      ((($countones(HWDATA[WIDTH-1:0]) + PARITYSEL + INJECT_FAULT) % 2) == 1);
          end
          8'h04: m_dir <= HWDATA[WIDTH-1:0];
          8'h08: m_en  <= HWDATA[WIDTH-1:0];
          8'h0C: m_pol <= HWDATA[WIDTH-1:0];
          8'h10: t_clr = HWDATA[WIDTH-1:0];
          8'h14: t_pclr = HWDATA[0];
          default: ;
        endcase
      end
      m_irq  <= (m_stat != '0);
      m_stat <= (m_stat & ~t_clr) | t_set;
      m_perr <= (m_perr && !t_pclr) || t_pe;
      for (int k = 7; k > 0; k--) ph[k] <= ph[k-1];
      ph[0] <= GPIOIN;
      if (HREADY) begin
        m_pend  <= HSEL && HTRANS[1] && HWRITE;
        m_paddr <= HADDR[7:0];
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [WIDTH-1:0] syn;
    syn = ph[SYNC-1][WIDTH-1:0];
    case (a)
      8'h00:   return {16'h0, (m_dir & m_dout) | (~m_dir & syn)};
      8'h04:   return {16'h0, m_dir};
      8'h08:   return {16'h0, m_en};
      8'h0C:   return {16'h0, m_pol};
      8'h10:   return {16'h0, m_stat};
      8'h14:   return {31'h0, m_perr & PAR_EN};
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle output comparison
  always @(negedge HCLK) begin
    if (chk_en) begin
      check("oe",        {16'h0, GPIOOE},  {16'h0, m_dir});
      check("gpioout",   {15'h0, GPIOOUT}, {15'h0, m_par, m_dout});
      check("irq",       {31'h0, IRQ},     {31'h0, m_irq});
      check("parityerr", {31'h0, PARITYERR}, {31'h0, m_perr});
      check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HADDR = {24'h0, a}; HTRANS = 2'b10; HWRITE = 1'b1;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    tick();
  endtask

  task automatic rd(input logic [7:0] a, input string nm, input bit lit_en, input logic [31:0] lit);
    HSEL = 1'b1; HADDR = {24'h0, a}; HTRANS = 2'b10; HWRITE = 1'b0;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    check({nm, "_model"}, HRDATA, model_read(a));
    if (lit_en) check(nm, HRDATA, lit);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] offs [6];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};

    repeat (2) @(posedge HCLK);
    #1;
    chk_en = 1'b1;
    HRESET = 1'b0;

    // Reset state
    foreach (offs[i]) rd(offs[i], "reset_rd", 1'b1, 32'h0);

    // Output data, direction and generated parity (0x1234 has five ones)
    wr(8'h04, 32'h0000_00FF);
    wr(8'h00, 32'h0000_1234);
    @(negedge HCLK);
    check("oe_lit", {16'h0, GPIOOE}, 32'h0000_00FF);
    check("out_even", {15'h0, GPIOOUT}, PAR_EN ? 32'h0001_1234 : 32'h0000_1234);
    tick();
    GPIOIN = 17'h0AB00;
    repeat (3) tick();
    rd(8'h00, "data_mixed", 1'b1, 32'h0000_AB34);

    INJECT_FAULT = 1'b1;
    wr(8'h00, 32'h0000_1234);
    @(negedge HCLK);
    check("out_inject", {15'h0, GPIOOUT}, 32'h0000_1234);
    tick();
    INJECT_FAULT = 1'b0;
    PARITYSEL = 1'b1;
    wr(8'h00, 32'h0000_1234);
    @(negedge HCLK);
    check("out_odd", {15'h0, GPIOOUT}, 32'h0000_1234);
    tick();
    PARITYSEL = 1'b0;

    // Rising-edge interrupt, latency SYNC+2
    GPIOIN = 17'h00000;
    repeat (3) tick();
    wr(8'h04, 32'h0);
    wr(8'h08, 32'h1);
    wr(8'h0C, 32'h0);
    GPIOIN = 17'h10001;
    for (int k = 1; k <= 4; k++) begin
      @(posedge HCLK);
      @(negedge HCLK);
      check("irq_latency", {31'h0, IRQ}, (k == 4) ? 32'h1 : 32'h0);
    end
    tick();
    rd(8'h10, "stat_rise", 1'b1, 32'h1);
    wr(8'h10, 32'h1);
    @(negedge HCLK);
    check("irq_hold", {31'h0, IRQ}, 32'h1);
    tick();
    @(negedge HCLK);
    check("irq_clr", {31'h0, IRQ}, 32'h0);
    tick();

    // Falling edge on bit1 coinciding with a W1C of bit1: set wins
    GPIOIN = 17'h00003;
    repeat (3) tick();
    wr(8'h0C, 32'h2);
    wr(8'h08, 32'h2);
    GPIOIN = 17'h10001;
    tick();
    wr(8'h10, 32'h2);
    rd(8'h10, "stat_set_wins", 1'b1, 32'h2);
    wr(8'h08, 32'h0);
    rd(8'h10, "stat_en_off", 1'b1, 32'h2);
    wr(8'h10, 32'h2);
    rd(8'h10, "stat_w1c", 1'b1, 32'h0);

    // Parity error: odd input with even parity selected
    GPIOIN = 17'h00001;
    for (int k = 1; k <= 3; k++) begin
      @(posedge HCLK);
      @(negedge HCLK);
      check("perr_latency", {31'h0, PARITYERR}, (PAR_EN && k == 3) ? 32'h1 : 32'h0);
    end
    tick();
    GPIOIN = 17'h10001;
    repeat (4) tick();
    @(negedge HCLK);
    check("perr_sticky", {31'h0, PARITYERR}, {31'h0, PAR_EN});
    tick();
    rd(8'h14, "par_stat", 1'b1, {31'h0, PAR_EN});
    wr(8'h14, 32'h1);
    @(negedge HCLK);
    check("perr_clr", {31'h0, PARITYERR}, 32'h0);
    tick();

    // Switching a bit to input while its synced value changes: no edge
    wr(8'h08, 32'h1);
    wr(8'h0C, 32'h0);
    wr(8'h04, 32'h1);
    GPIOIN = 17'h00000;
    repeat (4) tick();
    GPIOIN = 17'h10001;
    wr(8'h04, 32'h0);
    repeat (4) tick();
    rd(8'h10, "dir_switch", 1'b1, 32'h0);

    // Unmapped offset
    wr(8'h18, 32'hFFFF);
    rd(8'h18, "unmapped", 1'b1, 32'h0);

    // Reset during the data phase of a DATA write
    wr(8'h08, 32'hFFFF);
    wr(8'h04, 32'hFFFF);
    GPIOIN = 17'h00000;
    repeat (3) tick();
    HSEL = 1'b1; HADDR = 32'h0; HTRANS = 2'b10; HWRITE = 1'b1;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hFFFF;
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    @(negedge HCLK);
    check("rst_out", {15'h0, GPIOOUT}, 32'h0);
    check("rst_oe", {16'h0, GPIOOE}, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    tick();
    foreach (offs[i]) rd(offs[i], "rst_rd", 1'b1, 32'h0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
